// File: rtl/ram_arbiter.sv
// ram_arbiter: fetch/data arbiter in front of a single-port RAM, with a busy-cycle timeout.
// Define RAM_ARB_FAIR_EN to break simultaneous requests round-robin instead of data-port priority.
`timescale 1ns/1ps

package ram_arbiter_pkg;
    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;
endpackage

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  ram_addr_t  if_addr,
    output ram_data_t  if_rdata,
    output logic       if_ack,
    input  logic       mem_req,
    input  logic       mem_we,
    input  ram_addr_t  mem_addr,
    input  ram_data_t  mem_wdata,
    input  logic [3:0] mem_sel,
    output ram_data_t  mem_rdata,
    output logic       mem_ack,
    output logic       ram_ce,
    output logic       ram_we,
    output ram_addr_t  ram_addr,
    output ram_data_t  ram_wdata,
    output logic [3:0] ram_sel,
    input  ram_data_t  ram_rdata,
    input  logic       ram_ack,
    output logic       bus_err,
    output logic       stall_req
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_busy_cnt;
    logic       r_dropped;
    logic       w_busy;
    logic       w_owner_req;
    logic       w_timeout;
    logic       w_done;
    logic       w_owner_ok;
    logic       w_grant_if;
    logic       w_grant_mem;

    assign w_busy      = (r_state != IDLE);
    assign w_owner_req = (r_state == IF_BUSY) ? if_req : mem_req;
    assign w_timeout   = w_busy && !ram_ack && (r_busy_cnt == 8'(TIMEOUT - 1));
    assign w_done      = w_busy && (ram_ack || w_timeout);
    // An owner that let go of its request at any point during the transfer gets no ack.
    assign w_owner_ok  = w_done && w_owner_req && !r_dropped;

`ifdef RAM_ARB_FAIR_EN
    logic r_last_mem;

    assign w_grant_mem = mem_req && (!if_req || !r_last_mem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_mem <= 1'b1;
        end else if (r_state == IDLE && (if_req || mem_req)) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = mem_req;
`endif

    assign w_grant_if = if_req && !w_grant_mem;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_mem) begin
                    w_next_state = MEM_BUSY;
                end else if (w_grant_if) begin
                    w_next_state = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // On timeout ram_ack is low, so the owner's read data is forced to zero.
    always_comb begin
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        if_rdata  = '0;
        mem_rdata = '0;
        bus_err   = w_timeout;
        if (w_owner_ok) begin
            if (r_state == IF_BUSY) begin
                if_ack   = 1'b1;
                if_rdata = ram_ack ? ram_rdata : '0;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = ram_ack ? ram_rdata : '0;
            end
        end
    end

    assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy_cnt <= 8'd0;
            r_dropped  <= 1'b0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_sel    <= 4'h0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                r_busy_cnt <= 8'd0;
                r_dropped  <= 1'b0;
                if (w_grant_mem) begin
                    ram_ce    <= 1'b1;
                    ram_we    <= mem_we;
                    ram_addr  <= mem_addr;
                    ram_wdata <= mem_wdata;
                    ram_sel   <= mem_sel;
                end else if (w_grant_if) begin
                    ram_ce    <= 1'b1;
                    ram_we    <= 1'b0;
                    ram_addr  <= if_addr;
                    ram_wdata <= '0;
                    ram_sel   <= 4'hF;
                end
            end else if (w_done) begin
                ram_ce <= 1'b0;
                ram_we <= 1'b0;
            end else begin
                r_busy_cnt <= r_busy_cnt + 8'd1;
                if (!w_owner_req) begin
                    r_dropped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter covering fetch, store, ties, timeout, req drop and reset.
// The RAM is modelled by hand: ram_ack/ram_rdata are driven in the cycle after the command appears.
`timescale 1ns/1ps

module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       if_req;
    ram_addr_t  if_addr;
    ram_data_t  if_rdata;
    logic       if_ack;
    logic       mem_req;
    logic       mem_we;
    ram_addr_t  mem_addr;
    ram_data_t  mem_wdata;
    logic [3:0] mem_sel;
    ram_data_t  mem_rdata;
    logic       mem_ack;
    logic       ram_ce;
    logic       ram_we;
    ram_addr_t  ram_addr;
    ram_data_t  ram_wdata;
    logic [3:0] ram_sel;
    ram_data_t  ram_rdata;
    logic       ram_ack;
    logic       bus_err;
    logic       stall_req;

    int testsRun;
    int testsFailed;

    ram_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_sel   (ram_sel),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .bus_err   (bus_err),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] expMemPattern;
        testsRun    = 0;
        testsFailed = 0;
`ifdef RAM_ARB_FAIR_EN
        expMemPattern = 4'b1010;
`else
        expMemPattern = 4'b1111;
`endif
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = 4'h0;
        ram_rdata = '0;
        ram_ack   = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        applyStimulus();
        checkOutput("reset_ram_ce", 32'(ram_ce), 32'd0);
        checkOutput("reset_ram_sel", 32'(ram_sel), 32'd0);
        checkOutput("reset_ram_addr", ram_addr, 32'd0);
        checkOutput("reset_acks", {30'd0, if_ack, mem_ack}, 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        nextCycle();
        rst_n = 1'b1;

        // Fetch with the RAM answering the first busy cycle's command
        nextCycle();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        applyStimulus();
        checkOutput("fetch_c0_stall", 32'(stall_req), 32'd1);
        checkOutput("fetch_c0_ram_ce", 32'(ram_ce), 32'd0);
        nextCycle();
        applyStimulus();
        checkOutput("fetch_c1_stall", 32'(stall_req), 32'd1);
        checkOutput("fetch_c1_ram_ce", 32'(ram_ce), 32'd1);
        checkOutput("fetch_c1_ram_addr", ram_addr, 32'h0000_0100);
        checkOutput("fetch_c1_ram_we", 32'(ram_we), 32'd0);
        checkOutput("fetch_c1_ram_sel", 32'(ram_sel), 32'hF);
        checkOutput("fetch_c1_if_ack", 32'(if_ack), 32'd0);
        nextCycle();
        ram_ack   = 1'b1;
        ram_rdata = 32'h3C01_0001;
        applyStimulus();
        checkOutput("fetch_c2_if_ack", 32'(if_ack), 32'd1);
        checkOutput("fetch_c2_if_rdata", if_rdata, 32'h3C01_0001);
        checkOutput("fetch_c2_mem_ack", 32'(mem_ack), 32'd0);
        checkOutput("fetch_c2_stall", 32'(stall_req), 32'd0);
        nextCycle();
        if_req  = 1'b0;
        ram_ack = 1'b0;
        applyStimulus();
        checkOutput("fetch_c3_if_ack", 32'(if_ack), 32'd0);
        checkOutput("fetch_c3_if_rdata", if_rdata, 32'd0);
        checkOutput("fetch_c3_ram_ce", 32'(ram_ce), 32'd0);

        // Store held on the RAM bus until ram_ack arrives two busy cycles in
        nextCycle();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0080;
        mem_wdata = 32'hDEAD_BEEF;
        mem_sel   = 4'b0011;
        applyStimulus();
        checkOutput("store_c0_stall", 32'(stall_req), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            nextCycle();
            applyStimulus();
            checkOutput("store_busy_ram_ce", 32'(ram_ce), 32'd1);
            checkOutput("store_busy_ram_we", 32'(ram_we), 32'd1);
            checkOutput("store_busy_ram_sel", 32'(ram_sel), 32'b0011);
            checkOutput("store_busy_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
            checkOutput("store_busy_ram_addr", ram_addr, 32'h0000_0080);
            checkOutput("store_busy_mem_ack", 32'(mem_ack), 32'd0);
        end
        nextCycle();
        ram_ack   = 1'b1;
        ram_rdata = 32'h1234_5678;
        applyStimulus();
        checkOutput("store_ack_mem_ack", 32'(mem_ack), 32'd1);
        checkOutput("store_ack_mem_rdata", mem_rdata, 32'h1234_5678);
        checkOutput("store_ack_if_ack", 32'(if_ack), 32'd0);
        nextCycle();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        applyStimulus();
        checkOutput("idle_ram_ack_ignored", {30'd0, if_ack, mem_ack}, 32'd0);
        checkOutput("store_done_ram_ce", 32'(ram_ce), 32'd0);
        nextCycle();
        ram_ack = 1'b0;
        applyStimulus();
        checkOutput("idle_stays_idle", 32'(ram_ce), 32'd0);

        // Both ports requesting continuously, RAM acking every busy cycle
        nextCycle();
        if_req    = 1'b1;
        if_addr   = 32'h0000_1000;
        mem_req   = 1'b1;
        mem_addr  = 32'h0000_2000;
        mem_sel   = 4'hF;
        ram_ack   = 1'b1;
        ram_rdata = 32'h0000_AAAA;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus();
            checkOutput($sformatf("tie%0d_mem_ack", k), 32'(mem_ack), 32'(expMemPattern[k]));
            checkOutput($sformatf("tie%0d_if_ack", k), 32'(if_ack), 32'(!expMemPattern[k]));
            checkOutput($sformatf("tie%0d_ram_addr", k), ram_addr,
                        expMemPattern[k] ? 32'h0000_2000 : 32'h0000_1000);
            nextCycle();
            applyStimulus();
            checkOutput($sformatf("tie%0d_gap_ram_ce", k), 32'(ram_ce), 32'd0);
            checkOutput($sformatf("tie%0d_gap_acks", k), {30'd0, if_ack, mem_ack}, 32'd0);
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        ram_ack = 1'b0;

        // Timeout: RAM never answers, fault on the 16th busy cycle
        nextCycle();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0200;
        ram_rdata = 32'hFFFF_FFFF;
        applyStimulus();
        for (int i = 1; i <= 15; i++) begin
            nextCycle();
            applyStimulus();
            checkOutput($sformatf("timeout_busy%0d_bus_err", i), {30'd0, bus_err, if_ack}, 32'd0);
        end
        nextCycle();
        applyStimulus();
        checkOutput("timeout_bus_err", 32'(bus_err), 32'd1);
        checkOutput("timeout_if_ack", 32'(if_ack), 32'd1);
        checkOutput("timeout_if_rdata", if_rdata, 32'd0);
        nextCycle();
        if_req = 1'b0;
        applyStimulus();
        checkOutput("timeout_after_ram_ce", 32'(ram_ce), 32'd0);
        checkOutput("timeout_after_bus_err", 32'(bus_err), 32'd0);

        // Owner drops its request mid-transfer: RAM still completes, no ack
        nextCycle();
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0040;
        applyStimulus();
        nextCycle();
        mem_req = 1'b0;
        applyStimulus();
        checkOutput("drop_busy_ram_ce", 32'(ram_ce), 32'd1);
        nextCycle();
        ram_ack   = 1'b1;
        ram_rdata = 32'h5555_5555;
        applyStimulus();
        checkOutput("drop_mem_ack", 32'(mem_ack), 32'd0);
        checkOutput("drop_mem_rdata", mem_rdata, 32'd0);
        nextCycle();
        ram_ack = 1'b0;
        applyStimulus();
        checkOutput("drop_done_ram_ce", 32'(ram_ce), 32'd0);

        // Asynchronous reset in the middle of a data transfer
        nextCycle();
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0044;
        applyStimulus();
        nextCycle();
        applyStimulus();
        checkOutput("rst_busy_ram_ce", 32'(ram_ce), 32'd1);
        #1;
        rst_n   = 1'b0;
        mem_req = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        #1;
        checkOutput("rst_async_ram_ce", 32'(ram_ce), 32'd0);
        checkOutput("rst_async_mem_ack", 32'(mem_ack), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("rst_release_ram_ce", 32'(ram_ce), 32'd0);
        checkOutput("rst_release_stall", 32'(stall_req), 32'd1);
        nextCycle();
        applyStimulus();
        checkOutput("rst_regrant_ram_ce", 32'(ram_ce), 32'd1);
        checkOutput("rst_regrant_ram_addr", ram_addr, 32'h0000_0300);
        checkOutput("rst_regrant_ram_sel", 32'(ram_sel), 32'hF);
        nextCycle();
        ram_ack   = 1'b1;
        ram_rdata = 32'hCAFE_F00D;
        applyStimulus();
        checkOutput("rst_regrant_if_ack", 32'(if_ack), 32'd1);
        checkOutput("rst_regrant_if_rdata", if_rdata, 32'hCAFE_F00D);
        nextCycle();
        if_req  = 1'b0;
        ram_ack = 1'b0;
        applyStimulus();
        checkOutput("final_ram_ce", 32'(ram_ce), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: busy cycles without ram_ack before the transfer is aborted; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port if_req, input, 1: instruction-fetch request; held until if_ack.
REQ-005 SHALL have port if_addr, input, ram_addr_t: fetch address, stable while if_req is high.
REQ-006 SHALL have port if_rdata, output, ram_data_t: fetched word.
REQ-007 SHALL have port if_ack, output, 1: one-cycle completion pulse for the fetch.
REQ-008 SHALL have port mem_req, input, 1: load/store request; held until mem_ack.
REQ-009 SHALL have port mem_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have ports mem_addr, input, ram_addr_t; mem_wdata, input, ram_data_t; mem_sel, input, 4: data access address, write data and byte enables.
REQ-011 SHALL have ports mem_rdata, output, ram_data_t; and mem_ack, output, 1: load data and one-cycle completion pulse.
REQ-012 SHALL have ports ram_ce, ram_we, output, 1; ram_addr, output, ram_addr_t; ram_wdata, output, ram_data_t; ram_sel, output, 4: single-port RAM command.
REQ-013 SHALL have ports ram_rdata, input, ram_data_t; and ram_ack, input, 1: RAM read data and completion.
REQ-014 SHALL have ports bus_err, output, 1: one-cycle timeout pulse; and stall_req, output, 1: pipeline stall request.

Function
REQ-015 SHALL implement the FSM states IDLE, IF_BUSY and MEM_BUSY.
REQ-016 In IDLE with only if_req high, SHALL go to IF_BUSY; with only mem_req high, SHALL go to MEM_BUSY; with neither high, SHALL stay in IDLE.
REQ-017 With if_req and mem_req both high in IDLE, SHALL grant the data port (fixed priority) unless RAM_ARB_FAIR_EN is defined.
REQ-018 On entry to a BUSY state, SHALL register the winner's address, write data, byte enables and we onto the ram_* outputs, with ram_ce=1; a fetch drives ram_we=0 and ram_sel=4'hF.
REQ-019 In a BUSY state, SHALL hold all ram_* outputs stable until ram_ack or timeout.
REQ-020 On the cycle ram_ack=1 in a BUSY state, SHALL pulse the owner's ack combinationally and pass ram_rdata to the owner's rdata; SHALL register ram_ce=0 and return to IDLE.
REQ-021 Minimum latency from req to ack SHALL be 2 cycles (RAM acks in the first busy cycle); back-to-back grants SHALL leave at least one IDLE cycle between transfers.
REQ-022 if_rdata and mem_rdata SHALL be 0 whenever the corresponding ack is low.
REQ-023 SHALL run an 8-bit busy counter that clears on BUSY entry and increments each BUSY cycle without ram_ack.
REQ-024 When the counter reaches TIMEOUT-1 with no ram_ack, SHALL pulse bus_err and the owner's ack with rdata=0, deassert ram_ce, and return to IDLE.
REQ-025 ram_ack while in IDLE SHALL be ignored.
REQ-026 If the owner drops its req mid-transfer, SHALL complete the RAM transfer and suppress the owner's ack.
REQ-027 SHALL drive stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinationally.

Reset
REQ-028 On rst_n=0, SHALL immediately (asynchronously) force IDLE, clear the counter, clear the round-robin pointer, and drive ram_ce, ram_we, ram_addr, ram_wdata, ram_sel, bus_err and both acks to 0.
REQ-029 A reset during a BUSY state SHALL abandon the transfer with no ack; after rst_n rises, arbitration SHALL restart from IDLE.

Configuration
REQ-030 With RAM_ARB_FAIR_EN defined, SHALL keep a 1-bit last-granted pointer: on simultaneous requests, SHALL grant the port not granted last; the pointer resets to "data granted last", so instruction wins first.
REQ-031 Without RAM_ARB_FAIR_EN, the pointer SHALL NOT be present and the data port SHALL always win ties.

Verification
REQ-032 SHALL verify: if_req=1, if_addr=0x00000100, RAM acks on first busy cycle with rdata=0x3C010001 -> if_ack pulses at cycle 2 with if_rdata=0x3C010001, and stall_req is high cycles 0-1.
REQ-033 SHALL verify: mem_req=1, mem_we=1, mem_addr=0x80, mem_wdata=0xDEADBEEF, mem_sel=4'b0011 -> ram_we=1, ram_sel=0011, ram_wdata=0xDEADBEEF held until ram_ack, then mem_ack pulses once.
REQ-034 SHALL verify: both ports requesting continuously, without RAM_ARB_FAIR_EN -> data port is always granted; with it defined -> grants go IF, MEM, IF, MEM.
REQ-035 SHALL verify: ram_ack never asserted, TIMEOUT=16 -> bus_err and owner ack pulse on the 16th busy cycle, rdata=0, then state is IDLE.
REQ-036 SHALL verify: rst_n pulled low mid-MEM_BUSY -> ram_ce=0 asynchronously and no mem_ack; after release, a pending if_req is granted normally.
